psum_ofmap_writer: RTL and testbench



---
 rtl/psum_ofmap_writer.sv | 198 +++++++++++++++++++
 tb/tb_psum_ofmap_writer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_ofmap_writer.sv
// Accumulates per-lane partial sums across input-channel passes and, on the
// final pass, writes one ReLU'd, requantized ofmap word per column to SRAM.
module psum_ofmap_writer #(
    parameter int LANES    = 7,
    parameter int PSUM_W   = 16,
    parameter int ACC_W    = 24,
    parameter int OUT_W    = 8,
    parameter int MAX_COLS = 32,
    parameter int ADDR_W   = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_conv,
    input  logic [$clog2(MAX_COLS+1)-1:0] num_cols,
    input  logic [7:0]                    num_pass,
    input  logic [4:0]                    shift,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [LANES-1:0]              psum_valid,
    input  logic [LANES*PSUM_W-1:0]       psum_data,
    output logic [LANES-1:0]              psum_ack,
    output logic                          sram_wen,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [LANES*OUT_W-1:0]        sram_wdata,
    input  logic                          sram_ready,
    output logic                          busy,
    output logic                          done
);
    localparam int CW = $clog2(MAX_COLS + 1);
    localparam int IW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_ACCUM   = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           num_cols_q, col_q;
    logic [7:0]              num_pass_q, pass_q;
    logic [4:0]              shift_q;
    logic [ADDR_W-1:0]       base_q, addr_q;
    logic [LANES-1:0]        held_q, ack_q, capture_s;
    logic [LANES*PSUM_W-1:0] hold_q;
    logic [LANES*OUT_W-1:0]  wdata_q, wdata_s;
    logic                    wen_q, busy_q, done_q;
    logic                    last_col_s, last_pass_s, advance_s, all_held_s;
    logic [IW-1:0]           col_idx_s;
    logic signed [ACC_W-1:0] acc_q     [MAX_COLS][LANES];
    logic signed [ACC_W-1:0] acc_new_s [LANES];

    function automatic logic signed [ACC_W-1:0] sext_psum(input logic [PSUM_W-1:0] p);
        return {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
    endfunction

    // Overflow shows as disagreement between the two top bits of the widened sum.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                        input logic signed [ACC_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            return sum[ACC_W-1:0];
        end
    endfunction

    function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] a,
                                                 input logic [4:0] sh);
        logic signed [ACC_W-1:0] q;
        q = a >>> sh;
        if (a[ACC_W-1]) begin
            return {OUT_W{1'b0}};
        end else if (|q[ACC_W-1:OUT_W]) begin
            return {OUT_W{1'b1}};
        end else begin
            return q[OUT_W-1:0];
        end
    endfunction

    // Lane capture, column/pass bookkeeping and the accumulate/requantize datapath.
    always_comb begin
        capture_s   = (state_q == S_COLLECT) ? (psum_valid & ~held_q & ~ack_q) : {LANES{1'b0}};
        all_held_s  = &(held_q | capture_s);
        last_col_s  = (col_q == num_cols_q - CW'(1));
        last_pass_s = (pass_q == num_pass_q - 8'd1);
        advance_s   = ((state_q == S_ACCUM) && !last_pass_s) ||
                      ((state_q == S_WRITE) && sram_ready);
        col_idx_s   = col_q[IW-1:0];
        wdata_s     = {(LANES*OUT_W){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            if (pass_q == 8'd0) begin
                acc_new_s[i] = sext_psum(hold_q[i*PSUM_W +: PSUM_W]);
            end else begin
                acc_new_s[i] = sat_add(acc_q[col_idx_s][i], sext_psum(hold_q[i*PSUM_W +: PSUM_W]));
            end
            wdata_s[i*OUT_W +: OUT_W] = requant(acc_new_s[i], shift_q);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_conv) begin
                    state_d = ((num_cols == {CW{1'b0}}) || (num_pass == 8'd0)) ? S_DONE : S_COLLECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: state_d = all_held_s ? S_ACCUM : S_COLLECT;
            S_ACCUM:   state_d = last_pass_s ? S_WRITE : S_COLLECT;
            S_WRITE: begin
                if (sram_ready) begin
                    state_d = last_col_s ? S_DONE : S_COLLECT;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, configuration, lane holding registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            num_cols_q <= {CW{1'b0}};
            num_pass_q <= 8'd0;
            shift_q    <= 5'd0;
            base_q     <= {ADDR_W{1'b0}};
            col_q      <= {CW{1'b0}};
            pass_q     <= 8'd0;
            held_q     <= {LANES{1'b0}};
            ack_q      <= {LANES{1'b0}};
            hold_q     <= {(LANES*PSUM_W){1'b0}};
            wen_q      <= 1'b0;
            addr_q     <= {ADDR_W{1'b0}};
            wdata_q    <= {(LANES*OUT_W){1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= capture_s;
            wen_q   <= (state_d == S_WRITE);
            busy_q  <= (state_d == S_COLLECT) || (state_d == S_ACCUM) || (state_d == S_WRITE);
            done_q  <= (state_d == S_DONE);
            if ((state_q == S_IDLE) && start_conv) begin
                num_cols_q <= num_cols;
                num_pass_q <= num_pass;
                shift_q    <= shift;
                base_q     <= base_addr;
                col_q      <= {CW{1'b0}};
                pass_q     <= 8'd0;
                held_q     <= {LANES{1'b0}};
            end else if (advance_s) begin
                held_q <= {LANES{1'b0}};
                if (last_col_s) begin
                    col_q  <= {CW{1'b0}};
                    pass_q <= pass_q + 8'd1;
                end else begin
                    col_q  <= col_q + CW'(1);
                end
            end else begin
                held_q <= held_q | capture_s;
            end
            for (int i = 0; i < LANES; i++) begin
                if (capture_s[i]) begin
                    hold_q[i*PSUM_W +: PSUM_W] <= psum_data[i*PSUM_W +: PSUM_W];
                end
            end
            if (state_q == S_ACCUM) begin
                wdata_q <= wdata_s;
                addr_q  <= base_q + ADDR_W'(col_q);
            end
        end
    end

    // Accumulator array; contents are meaningless until the first pass of a column.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCUM) begin
            for (int i = 0; i < LANES; i++) begin
                acc_q[col_idx_s][i] <= acc_new_s[i];
            end
        end
    end

    assign psum_ack   = ack_q;
    assign sram_wen   = wen_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_psum_ofmap_writer.sv
// Randomized bench for psum_ofmap_writer: per-lane handshaking drivers, random
// SRAM backpressure and a plain-arithmetic accumulate/requantize model.
module tb_psum_ofmap_writer;
    localparam int LANES = 7, PSUM_W = 16, ACC_W = 24, SAT_W = 18, OUT_W = 8;
    localparam int MAX_COLS = 32, ADDR_W = 10;
    localparam int CW = $clog2(MAX_COLS + 1);
    localparam int WW = LANES * OUT_W;

    logic                    clk = 1'b0, rst_n = 1'b0, start_conv = 1'b0;
    logic [CW-1:0]           num_cols = '0;
    logic [7:0]              num_pass = '0;
    logic [4:0]              shift = '0;
    logic [ADDR_W-1:0]       base_addr = '0;
    logic [LANES-1:0]        psum_valid = '0, psum_ack, psum_ack2;
    logic [LANES*PSUM_W-1:0] psum_data = '0;
    logic                    sram_wen, sram_wen2, sram_ready = 1'b0;
    logic                    busy, busy2, done, done2;
    logic [ADDR_W-1:0]       sram_addr, sram_addr2;
    logic [WW-1:0]           sram_wdata, sram_wdata2;

    psum_ofmap_writer #(.LANES(LANES), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
                        .MAX_COLS(MAX_COLS), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_conv(start_conv), .num_cols(num_cols),
        .num_pass(num_pass), .shift(shift), .base_addr(base_addr),
        .psum_valid(psum_valid), .psum_data(psum_data), .psum_ack(psum_ack),
        .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_ready(sram_ready), .busy(busy), .done(done));

    // Narrow-accumulator twin so that saturation is reachable with 8-bit pass counts.
    psum_ofmap_writer #(.LANES(LANES), .PSUM_W(PSUM_W), .ACC_W(SAT_W), .OUT_W(OUT_W),
                        .MAX_COLS(MAX_COLS), .ADDR_W(ADDR_W)) u_sat (
        .clk(clk), .rst_n(rst_n), .start_conv(start_conv), .num_cols(num_cols),
        .num_pass(num_pass), .shift(shift), .base_addr(base_addr),
        .psum_valid(psum_valid), .psum_data(psum_data), .psum_ack(psum_ack2),
        .sram_wen(sram_wen2), .sram_addr(sram_addr2), .sram_wdata(sram_wdata2),
        .sram_ready(sram_ready), .busy(busy2), .done(done2));

    always #5 clk = ~clk;

    int            n_tests = 0, n_fail = 0;
    int            pv [256][MAX_COLS][LANES];
    int            lq [LANES][$];
    int            dly [LANES];
    logic [WW-1:0] got_q[$], got2_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint clampw(input longint v, input int w);
        longint hi;
        hi = (longint'(1) << (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    function automatic int rq(input longint a, input int sh);
        longint q;
        if (a < 0) return 0;
        q = a >>> sh;
        return (q > 255) ? 255 : int'(q);
    endfunction

    task automatic fill_rand(input int np, input int nc);
        logic signed [15:0] r;
        for (int p = 0; p < np; p++)
            for (int c = 0; c < nc; c++)
                for (int l = 0; l < LANES; l++) begin
                    r = 16'($urandom);
                    pv[p][c][l] = r;
                end
    endtask

    task automatic rand_dly();
        for (int l = 0; l < LANES; l++) dly[l] = $urandom_range(0, 3);
    endtask

    // abort: 0 none, 1 reset when a write is pending, 2 reset while an ack is high
    task automatic run_test(input int ncols, input int npass, input int sh, input int base,
                            input int rmode, input bit poke, input int abort);
        longint        a1 [MAX_COLS][LANES];
        longint        a2 [MAX_COLS][LANES];
        logic [ADDR_W-1:0] ea_q[$];
        logic [WW-1:0] ed_q[$], ed2_q[$];
        logic [WW-1:0] w1, w2, pd;
        logic [ADDR_W-1:0] pa;
        logic [LANES-1:0]  pack;
        logic          pw, pr;
        int            cyc, done_cyc, last_hs, bp, nexp;
        got_q.delete();
        got2_q.delete();
        for (int l = 0; l < LANES; l++) lq[l].delete();
        for (int p = 0; p < npass; p++)
            for (int c = 0; c < ncols; c++) begin
                w1 = '0;
                w2 = '0;
                for (int l = 0; l < LANES; l++) begin
                    lq[l].push_back(pv[p][c][l]);
                    a1[c][l] = (p == 0) ? longint'(pv[p][c][l]) : clampw(a1[c][l] + pv[p][c][l], ACC_W);
                    a2[c][l] = (p == 0) ? longint'(pv[p][c][l]) : clampw(a2[c][l] + pv[p][c][l], SAT_W);
                    w1[l*OUT_W +: OUT_W] = 8'(rq(a1[c][l], sh));
                    w2[l*OUT_W +: OUT_W] = 8'(rq(a2[c][l], sh));
                end
                if (p == npass - 1) begin
                    ea_q.push_back(ADDR_W'(base + c));
                    ed_q.push_back(w1);
                    ed2_q.push_back(w2);
                end
            end
        nexp = ea_q.size();
        @(negedge clk);
        start_conv = 1'b1;
        num_cols   = CW'(ncols);
        num_pass   = 8'(npass);
        shift      = 5'(sh);
        base_addr  = ADDR_W'(base);
        cyc = 0; done_cyc = -1; last_hs = 0; bp = 0; pw = 1'b0; pr = 1'b0; pack = '0;
        pa = '0; pd = '0;
        while (done_cyc < 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start_conv = poke && (cyc == 3);
            if (poke && cyc == 2) begin
                num_cols  = CW'($urandom_range(0, MAX_COLS));
                num_pass  = 8'($urandom);
                shift     = 5'($urandom);
                base_addr = ADDR_W'($urandom);
            end
            if (cyc == 1) chk("busy_start", 64'(busy), 64'(ncols != 0 && npass != 0));
            chk("twin_ctl", {psum_ack2, sram_wen2, busy2, done2, sram_addr2},
                            {psum_ack, sram_wen, busy, done, sram_addr});
            chk("ack_pulse", 64'(psum_ack & pack), 64'd0);
            chk("ack_valid", 64'(psum_ack & ~psum_valid), 64'd0);
            if (sram_wen) chk("ack_in_write", 64'(psum_ack), 64'd0);
            if ((abort == 1 && sram_wen) || (abort == 2 && psum_ack != '0)) begin
                #2 rst_n = 1'b0;
                #1 chk("rst_abort", {sram_wen, busy, done, psum_ack}, 64'd0);
                psum_valid = '0;
                sram_ready = 1'b0;
                start_conv = 1'b0;
                for (int l = 0; l < LANES; l++) lq[l].delete();
                @(negedge clk);
                chk("rst_hold", {sram_wen, busy, psum_ack}, 64'd0);
                rst_n = 1'b1;
                return;
            end
            for (int l = 0; l < LANES; l++) begin
                if (psum_ack[l]) begin
                    if (lq[l].size() > 0) void'(lq[l].pop_front());
                    psum_valid[l] = 1'b0;
                    dly[l] = $urandom_range(0, 3);
                end
                if (!psum_valid[l] && lq[l].size() > 0) begin
                    if (dly[l] == 0) begin
                        psum_valid[l] = 1'b1;
                        psum_data[l*PSUM_W +: PSUM_W] = 16'(lq[l][0]);
                    end else begin
                        dly[l]--;
                    end
                end
            end
            if (pw && !pr) chk("bp_hold", {sram_wen, sram_addr, sram_wdata[47:0]}, {1'b1, pa, pd[47:0]});
            case (rmode)
                0: sram_ready = 1'b1;
                1: sram_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (sram_wen && bp < 4) begin
                        sram_ready = 1'b0;
                        bp++;
                    end else begin
                        sram_ready = 1'b1;
                    end
                end
                default: sram_ready = 1'b0;
            endcase
            if (sram_wen && sram_ready) begin
                bp = 0;
                last_hs = cyc;
                if (ea_q.size() == 0) begin
                    chk("extra_write", 64'd1, 64'd0);
                end else begin
                    chk("waddr", 64'(sram_addr), 64'(ea_q.pop_front()));
                    chk("wdata", 64'(sram_wdata), 64'(ed_q.pop_front()));
                    chk("wdata_sat", 64'(sram_wdata2), 64'(ed2_q.pop_front()));
                    got_q.push_back(sram_wdata);
                    got2_q.push_back(sram_wdata2);
                end
            end
            if (done) done_cyc = cyc;
            pw = sram_wen; pr = sram_ready; pa = sram_addr; pd = sram_wdata; pack = psum_ack;
        end
        start_conv = 1'b0;
        psum_valid = '0;
        if (abort != 0) chk("abort_reached", 64'd0, 64'd1);
        chk("done_seen", 64'(done_cyc >= 0), 64'd1);
        chk("done_cyc", 64'(done_cyc), 64'((nexp == 0) ? 1 : last_hs + 1));
        chk("writes_left", 64'(ea_q.size()), 64'd0);
        for (int l = 0; l < LANES; l++) chk("lane_left", 64'(lq[l].size()), 64'd0);
        @(negedge clk);
        chk("done_pulse", {done, busy, sram_wen}, 64'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ctl", {sram_wen, busy, done, psum_ack, sram_addr}, 64'd0);
        chk("rst_data", 64'(sram_wdata), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pass, lane values 1..7 then saturating 300.
        for (int l = 0; l < LANES; l++) begin
            pv[0][0][l] = l + 1;
            pv[0][1][l] = 300;
        end
        rand_dly();
        run_test(2, 1, 0, 'h10, 0, 1'b0, 0);
        chk("t1_count", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("t1_w0", 64'(got_q[0]), 64'h07060504030201);
            chk("t1_w1", 64'(got_q[1]), 64'hFFFFFFFFFFFFFF);
        end

        // Multi-pass with ReLU on the negative lanes.
        for (int l = 0; l < LANES; l++)
            for (int p = 0; p < 3; p++) pv[p][0][l] = -1;
        pv[0][0][0] = 10; pv[1][0][0] = 20; pv[2][0][0] = -5;
        rand_dly();
        run_test(1, 3, 2, 'h20, 1, 1'b0, 0);
        chk("t2_count", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) chk("t2_w0", 64'(got_q[0]), 64'h06);

        // Staggered lanes: lane 6 first, lane 0 five cycles later.
        fill_rand(2, 2);
        for (int l = 0; l < LANES; l++) dly[l] = 2;
        dly[6] = 0; dly[0] = 5;
        run_test(2, 2, 1, 5, 1, 1'b0, 0);

        // Backpressure: every write stalls four cycles.
        fill_rand(1, 3);
        rand_dly();
        run_test(3, 1, 3, 'h40, 2, 1'b1, 0);

        // Saturation: 255 passes; lane 1 drives negative then positive.
        for (int p = 0; p < 255; p++)
            for (int l = 0; l < LANES; l++)
                pv[p][0][l] = (l == 0) ? 32767 : (l == 1) ? ((p < 200) ? -32768 : 32767) : 0;
        rand_dly();
        run_test(1, 255, 10, 0, 0, 1'b0, 0);
        if (got_q.size() == 1) begin
            chk("sat_w24", 64'(got_q[0]), 64'hFF);
            chk("sat_w18", 64'(got2_q[0]), 64'h7F7F);
        end

        // Degenerate configurations produce done with no writes.
        run_test(3, 0, 0, 0, 0, 1'b0, 0);
        run_test(0, 2, 0, 0, 0, 1'b0, 0);

        // Asynchronous reset in WRITE and with an ack outstanding, then a clean run.
        fill_rand(1, 2);
        rand_dly();
        run_test(2, 1, 0, 'h80, 3, 1'b0, 1);
        fill_rand(1, 2);
        rand_dly();
        run_test(2, 1, 0, 'h80, 0, 1'b0, 2);
        fill_rand(2, 3);
        rand_dly();
        run_test(3, 2, 4, 'h100, 1, 1'b0, 0);

        // Random configurations, including address wrap.
        for (int t = 0; t < 6; t++) begin
            int nc, np;
            nc = $urandom_range(1, 6);
            np = $urandom_range(1, 4);
            fill_rand(np, nc);
            rand_dly();
            run_test(nc, np, $urandom_range(0, 12), (t == 0) ? 'h3FE : $urandom_range(0, 1023),
                     1, nc >= 2, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
